wb_sequencer: RTL and testbench

//  Multicycle controller that sequences the writeback path of the datapath.
//  - Accepts one decoded instruction at a time: a one-hot opcode plus a destination register.
//  - Drives the data-memory read/write strobes and waits for memory acknowledge.
//  - Drives the writeback mux select (memory vs ALU result) and the register-file write enable.
//  - Selects are registered and stable, so the combinational writeback mux never sees an undecoded opcode.

---
 rtl/wb_sequencer_if.sv | 39 +++
 rtl/wb_sequencer.sv | 128 ++++++++++++
 tb/tb_wb_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_sequencer_if : instruction handshake, data-memory strobes and writeback
// Revision 1.0
// ---------------------------------------------------------------------------
interface wb_sequencer_if #(
    parameter int OP_W  = 20,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OP_W-1:0]  op_onehot;
    logic [RA_W-1:0]  rd_addr;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic             mem_ready;
    logic             wb_sel;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired_cnt;

    // Decoder / memory side
    modport master (
        output instr_valid, op_onehot, rd_addr, mem_ready,
        input  instr_ready, mem_rd_en, mem_wr_en, wb_sel, rf_we, rf_waddr,
               illegal_op, mem_timeout, retired_cnt
    );

    // Sequencer side
    modport slave (
        input  instr_valid, op_onehot, rd_addr, mem_ready,
        output instr_ready, mem_rd_en, mem_wr_en, wb_sel, rf_we, rf_waddr,
               illegal_op, mem_timeout, retired_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_sequencer : multicycle IDLE/MEM/WB controller for the writeback path
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_sequencer #(
    parameter int OP_W        = 20,
    parameter int RA_W        = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    wb_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [7:0]      c_timeout   = 8'(MEM_TIMEOUT);
    localparam logic [OP_W-1:0] c_nowb_mask = OP_W'(20'h3C000);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_is_load;
    logic [RA_W-1:0]  r_rd;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_nxt;
    logic             r_wb_sel;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic w_onehot;
    logic w_is_mem;
    logic w_is_nowb;
    logic w_accept;
    logic w_retire;
    logic w_illegal_nxt;
    logic w_timeout_nxt;

    assign w_onehot  = (bus.op_onehot != '0) &&
                       ((bus.op_onehot & (bus.op_onehot - OP_W'(1))) == '0);
    assign w_is_mem  = bus.op_onehot[2] | bus.op_onehot[3];
    assign w_is_nowb = |(bus.op_onehot & c_nowb_mask);

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_accept      = 1'b0;
        w_retire      = 1'b0;
        w_illegal_nxt = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_accept   = 1'b1;
                    w_wait_nxt = 8'd0;
                    if (!w_onehot)      w_illegal_nxt = 1'b1;
                    else if (w_is_mem)  w_state_nxt   = S_MEM;
                    else if (w_is_nowb) w_retire      = 1'b1;
                    else                w_state_nxt   = S_WB;
                end
            end
            S_MEM: begin
                // An acknowledge arriving on the expiry cycle still completes the access
                if (bus.mem_ready) begin
                    if (r_is_load) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_retire    = 1'b1;
                    end
                end else if (r_wait == c_timeout - 8'd1) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
            r_rd      <= '0;
            r_wait    <= 8'd0;
            r_wb_sel  <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_illegal <= w_illegal_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_accept) begin
                r_is_load <= bus.op_onehot[2];
                r_rd      <= bus.rd_addr;
            end
            // Select only moves on WB entry so the mux input stays stable otherwise
            if (w_state_nxt == S_WB && r_state != S_WB)
                r_wb_sel <= (r_state == S_MEM);
            if (w_retire)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE) && reset_n;
    assign bus.mem_rd_en   = (r_state == S_MEM) &&  r_is_load;
    assign bus.mem_wr_en   = (r_state == S_MEM) && !r_is_load;
    assign bus.rf_we       = (r_state == S_WB);
    assign bus.rf_waddr    = r_rd;
    assign bus.wb_sel      = r_wb_sel;
    assign bus.illegal_op  = r_illegal;
    assign bus.mem_timeout = r_timeout;
    assign bus.retired_cnt = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_wb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_sequencer : randomized transaction bench with a per-class timing model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb_sequencer;
    localparam int c_op_w    = 20;
    localparam int c_ra_w    = 5;
    localparam int c_cnt_w   = 8;
    localparam int c_timeout = 15;

    localparam int K_ILL   = 0;
    localparam int K_ALU   = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_NOWB  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_sequencer_if #(.OP_W(c_op_w), .RA_W(c_ra_w), .CNT_W(c_cnt_w)) bus ();

    wb_sequencer #(
        .OP_W(c_op_w), .RA_W(c_ra_w), .MEM_TIMEOUT(c_timeout), .CNT_W(c_cnt_w)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int              n_checks = 0;
    int              n_errors = 0;
    int              exp_cnt  = 0;
    logic            exp_wb_sel = 1'b0;
    logic [4:0]      exp_waddr  = 5'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {instr_ready, mem_rd_en, mem_wr_en, rf_we, illegal_op, mem_timeout}
    function automatic logic [31:0] flags();
        return {26'd0, bus.instr_ready, bus.mem_rd_en, bus.mem_wr_en,
                bus.rf_we, bus.illegal_op, bus.mem_timeout};
    endfunction

    function automatic int classify(input logic [19:0] op);
        if ($countones(op) != 1) return K_ILL;
        for (int i = 0; i < 20; i++) begin
            if (op[i]) begin
                if (i == 2) return K_LOAD;
                if (i == 3) return K_STORE;
                if (i >= 14 && i <= 17) return K_NOWB;
                return K_ALU;
            end
        end
        return K_ILL;
    endfunction

    // Called at a negedge with the sequencer idle; returns at the negedge of
    // the first cycle in which it is expected to be idle again.
    task automatic run_op(input logic [19:0] op, input logic [4:0] rd, input int delay);
        int   k;
        bit   is_mem;
        bit   rdy;
        int   memc;
        int   endc;
        logic [31:0] ef;
        k      = classify(op);
        is_mem = (k == K_LOAD) || (k == K_STORE);
        rdy    = delay < c_timeout;
        memc   = rdy ? delay + 1 : c_timeout;
        case (k)
            K_ALU:   endc = 2;
            K_LOAD:  endc = rdy ? memc + 2 : memc + 1;
            K_STORE: endc = memc + 1;
            default: endc = 1;
        endcase
        exp_waddr = rd;
        if (k == K_ALU) exp_wb_sel = 1'b0;
        if (k == K_LOAD && rdy) exp_wb_sel = 1'b1;
        if (k == K_ALU || k == K_NOWB || (is_mem && rdy))
            exp_cnt = (exp_cnt + 1) % (1 << c_cnt_w);

        bus.instr_valid = 1'b1;
        bus.op_onehot   = op;
        bus.rd_addr     = rd;
        bus.mem_ready   = 1'b0;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            if (is_mem) bus.mem_ready = rdy && (c == delay + 1);
            else        bus.mem_ready = 1'($urandom % 2);
            if (c < endc) begin
                bus.instr_valid = 1'($urandom % 2);
                bus.op_onehot   = 20'($urandom);
                bus.rd_addr     = 5'($urandom);
            end else begin
                bus.instr_valid = 1'b0;
            end
            ef = 32'd0;
            ef[5] = (c >= endc);
            ef[4] = (k == K_LOAD)  && (c <= memc);
            ef[3] = (k == K_STORE) && (c <= memc);
            ef[2] = ((k == K_ALU) && (c == 1)) || ((k == K_LOAD) && rdy && (c == memc + 1));
            ef[1] = (k == K_ILL) && (c == 1);
            ef[0] = is_mem && !rdy && (c == c_timeout + 1);
            check_eq($sformatf("flags op=%05h d=%0d c=%0d", op, delay, c), flags(), ef);
            if (ef[2]) begin
                check_eq("rf_waddr at we", 32'(bus.rf_waddr), 32'(rd));
                check_eq("wb_sel at we",   32'(bus.wb_sel),   32'(exp_wb_sel));
            end
        end
        check_eq("retired_cnt", 32'(bus.retired_cnt), 32'(exp_cnt));
        check_eq("rf_waddr hold", 32'(bus.rf_waddr), 32'(exp_waddr));
        check_eq("wb_sel hold", 32'(bus.wb_sel), 32'(exp_wb_sel));
    endtask

    initial begin
        logic [19:0] rop;
        int          r;
        int          d;
        bus.instr_valid = 1'b0;
        bus.op_onehot   = '0;
        bus.rd_addr     = '0;
        bus.mem_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset flags", flags(), 32'd0);
        check_eq("reset rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check_eq("reset wb_sel", 32'(bus.wb_sel), 32'd0);
        check_eq("reset retired_cnt", 32'(bus.retired_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle after reset", flags(), 32'h20);

        run_op(20'h00001, 5'd3, 0);     // ADD
        run_op(20'h00004, 5'd7, 3);     // LOAD, ack after 3 waits
        run_op(20'h00008, 5'd1, 99);    // STORE, never acked
        run_op(20'h00000, 5'd2, 0);     // no bit set
        run_op(20'h00005, 5'd4, 0);     // two bits set
        run_op(20'h00004, 5'd6, 14);    // ack on the expiry cycle
        run_op(20'h00008, 5'd8, 0);     // STORE, immediate ack

        // Reset while a LOAD waits in MEM
        bus.instr_valid = 1'b1;
        bus.op_onehot   = 20'h00004;
        bus.rd_addr     = 5'd9;
        bus.mem_ready   = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check_eq("load in mem", flags(), 32'h10);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("flags after mid-load reset", flags(), 32'd0);
        check_eq("cnt after mid-load reset", 32'(bus.retired_cnt), 32'd0);
        reset_n = 1'b1;
        exp_cnt = 0; exp_wb_sel = 1'b0; exp_waddr = 5'd0;
        @(negedge clk);
        check_eq("idle after mid-load reset", flags(), 32'h20);
        run_op(20'h40000, 5'd12, 0);    // MOVE

        // Walk the counter to just below wrap, then stream two ALU ops
        for (int i = 0; i < 400 && exp_cnt != (1 << c_cnt_w) - 2; i++)
            run_op(20'h04000 << ($urandom % 4), 5'($urandom), 0);
        bus.instr_valid = 1'b1;
        bus.op_onehot   = 20'h00010;
        bus.rd_addr     = 5'd21;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.rd_addr = 5'd22;
            if (c == 4) bus.instr_valid = 1'b0;
            check_eq($sformatf("stream flags c=%0d", c), flags(), (c % 2 == 0) ? 32'h20 : 32'h04);
            if (c == 1) check_eq("stream waddr 1", 32'(bus.rf_waddr), 32'd21);
            if (c == 3) check_eq("stream waddr 2", 32'(bus.rf_waddr), 32'd22);
            if (c == 2) check_eq("cnt before wrap", 32'(bus.retired_cnt), 32'((1 << c_cnt_w) - 1));
            if (c == 4) check_eq("cnt wrapped", 32'(bus.retired_cnt), 32'd0);
        end
        exp_cnt = 0; exp_waddr = 5'd22; exp_wb_sel = 1'b0;

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom % 12);
            if (r == 0)      rop = 20'h00000;
            else if (r == 1) rop = 20'($urandom) | 20'h00003;
            else if (r < 4)  rop = 20'h00004 << ($urandom % 2);
            else             rop = 20'h00001 << ($urandom % 20);
            d = ($urandom % 5 == 0) ? 14 + int'($urandom % 4) : int'($urandom % 10);
            run_op(rop, 5'($urandom), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
